// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle: FIFO read port (pop strobe, flag, data, pointers) plus the
// downstream valid/ready stream driven by fifo_rd_stream.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 3
);
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic [PTR_WIDTH:0]    rptr;
    logic [PTR_WIDTH:0]    rq2_wptr;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // master: the stream consumer block (pops the FIFO, sources the stream)
    modport master (
        input  rempty, rdata, rptr, rq2_wptr, m_ready,
        output rinc, m_data, m_valid
    );

    // slave: FIFO read logic plus the downstream sink
    modport slave (
        output rempty, rdata, rptr, rq2_wptr, m_ready,
        input  rinc, m_data, m_valid
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Async FIFO read-domain consumer: pops words into a 2-entry skid buffer that
// drives a registered valid/ready stream, and reports read-side occupancy.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 3
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 flush,
    fifo_rd_stream_if.master     bus,
    output logic [PTR_WIDTH:0]   rlevel
);
    localparam int unsigned PW = PTR_WIDTH + 1;
    localparam int unsigned DW = DATA_WIDTH;

    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] slot0_q, slot0_d;
    logic [DW-1:0] slot1_q, slot1_d;
    logic          m_valid_q;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rinc;
    logic          push, pop;
    logic [PW-1:0] wbin, rbin;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int i = 0; i < int'(PW); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Pop only from registered state; m_ready never reaches rinc.
    assign rinc = !bus.rempty && (cnt_q != 2'd2) && !flush;

    always_comb begin
        push     = rinc;
        pop      = m_valid_q && bus.m_ready;
        cnt_d    = cnt_q;
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        wbin     = gray2bin(bus.rq2_wptr);
        rbin     = gray2bin(bus.rptr);
        rlevel_d = wbin - rbin;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) slot0_d = bus.rdata;
                    else               slot1_d = bus.rdata;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    cnt_d   = cnt_q - 2'd1;
                end
                // push+pop only reachable with one word buffered
                2'b11: slot0_d = bus.rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q     <= 2'd0;
            slot0_q   <= '0;
            slot1_q   <= '0;
            m_valid_q <= 1'b0;
            rlevel_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            m_valid_q <= (cnt_d != 2'd0);
            rlevel_q  <= rlevel_d;
        end
    end

    assign bus.rinc    = rinc;
    assign bus.m_data  = slot0_q;
    assign bus.m_valid = m_valid_q;
    assign rlevel      = rlevel_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO read side, scoreboard of popped
// words checked against the stream by a negedge monitor.
module tb_fifo_rd_stream;
    localparam int unsigned DW   = 8;
    localparam int unsigned PW   = 3;
    localparam int unsigned PTRW = PW + 1;

    logic            rclk = 1'b0;
    logic            rrst_n;
    logic            flush;
    logic [PTRW-1:0] rlevel;

    fifo_rd_stream_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

    fifo_rd_stream #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .flush  (flush),
        .bus    (bus.master),
        .rlevel (rlevel)
    );

    always #5 rclk = ~rclk;

    int            total = 0;
    int            bad = 0;
    int            delivered = 0;
    int            rinc_pulses = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_data = '0;
    logic          pop_pending = 1'b0;
    int unsigned   wcnt = 0;
    int unsigned   rcnt = 0;
    bit            ptr_override = 1'b0;

    function automatic logic [PTRW-1:0] bin2gray(input logic [PTRW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model outputs: empty flag, head word, gray pointers
    task automatic refresh();
        bus.rempty = (fifo_q.size() == 0);
        bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        if (!ptr_override) begin
            bus.rq2_wptr = bin2gray(PTRW'(wcnt));
            bus.rptr     = bin2gray(PTRW'(rcnt));
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
        if (pop_pending) begin
            void'(fifo_q.pop_front());
            rcnt++;
        end
        refresh();
    endtask

    task automatic write(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        wcnt++;
        refresh();
    endtask

    task automatic wait_deliv(input int target, input int budget);
        int n;
        n = 0;
        while (delivered < target && n < budget) begin
            step();
            n++;
        end
        check("deliver_count", delivered, target);
    endtask

    // Monitor / scoreboard
    always @(negedge rclk) begin
        logic [DW-1:0] e;
        pop_pending = rrst_n && bus.rinc;
        if (rrst_n) begin
            check("rinc_when_empty", 32'(bus.rinc & bus.rempty), 32'd0);
            if (flush) begin
                check("rinc_during_flush", 32'(bus.rinc), 32'd0);
                exp_q.delete();
            end else if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(bus.m_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_data", 32'(bus.m_data), 32'(e));
                end
                delivered++;
                last_data = bus.m_data;
            end
            if (bus.rinc) begin
                exp_q.push_back(bus.rdata);
                rinc_pulses++;
            end
            check("buffer_depth_le2", 32'(exp_q.size() > 2), 32'd0);
        end
    end

    typedef struct {
        logic [PTRW-1:0] rb;
        logic [PTRW-1:0] wb;
        logic [PTRW-1:0] lvl;
    } occ_t;

    initial begin
        int   base_d;
        int   base_r;
        int   n;
        occ_t occ[3];

        rrst_n = 1'b0;
        flush = 1'b0;
        bus.m_ready = 1'b0;
        bus.rq2_wptr = '0;
        bus.rptr = '0;
        refresh();

        // Reset
        repeat (3) @(negedge rclk);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_rinc", 32'(bus.rinc), 32'd0);
        check("rst_rlevel", 32'(rlevel), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        @(posedge rclk);
        #1 rrst_n = 1'b1;
        repeat (3) step();
        @(negedge rclk);
        check("idle_m_valid", 32'(bus.m_valid), 32'd0);
        check("idle_rinc", 32'(bus.rinc), 32'd0);
        check("idle_rlevel", 32'(rlevel), 32'd0);

        // Streaming 0x11..0x18 with m_ready held high
        step();
        bus.m_ready = 1'b1;
        base_d = delivered;
        base_r = rinc_pulses;
        for (int i = 0; i < 8; i++) write(8'(8'h11 + i));
        @(negedge rclk);
        check("first_rinc", 32'(bus.rinc), 32'd1);
        check("first_m_valid_lo", 32'(bus.m_valid), 32'd0);
        step();
        @(negedge rclk);
        check("first_m_valid_hi", 32'(bus.m_valid), 32'd1);
        check("first_m_data", 32'(bus.m_data), 32'h11);
        repeat (8) step();
        check("stream_count", delivered - base_d, 32'd8);
        check("stream_rinc_pulses", rinc_pulses - base_r, 32'd8);
        check("stream_done_valid", 32'(bus.m_valid), 32'd0);
        check("stream_last", 32'(last_data), 32'h18);

        // Backpressure: 4 words, stalled for 5 cycles
        bus.m_ready = 1'b0;
        base_d = delivered;
        base_r = rinc_pulses;
        for (int i = 0; i < 4; i++) write(8'(8'h21 + i));
        repeat (2) step();
        check("bp_hold_data_early", 32'(bus.m_data), 32'h21);
        repeat (3) step();
        check("bp_rinc_pulses", rinc_pulses - base_r, 32'd2);
        check("bp_m_valid", 32'(bus.m_valid), 32'd1);
        check("bp_hold_data", 32'(bus.m_data), 32'h21);
        check("bp_no_delivery", delivered - base_d, 32'd0);
        bus.m_ready = 1'b1;
        wait_deliv(base_d + 4, 20);
        check("bp_fifo_drained", fifo_q.size(), 32'd0);
        check("bp_last", 32'(last_data), 32'h24);

        // Flush with two words buffered and one left in the FIFO
        bus.m_ready = 1'b0;
        write(8'hA0);
        write(8'hA1);
        write(8'hA2);
        n = 0;
        while (exp_q.size() < 2 && n < 10) begin
            step();
            n++;
        end
        step();
        @(negedge rclk);
        check("fl_full_rinc", 32'(bus.rinc), 32'd0);
        check("fl_head", 32'(bus.m_data), 32'hA0);
        step();
        base_d = delivered;
        flush = 1'b1;
        bus.m_ready = 1'b1;
        step();
        flush = 1'b0;
        @(negedge rclk);
        check("fl_m_valid", 32'(bus.m_valid), 32'd0);
        wait_deliv(base_d + 1, 10);
        check("fl_next_word", 32'(last_data), 32'hA2);
        repeat (2) step();

        // Occupancy wrap: (rbin, wbin) -> level
        occ[0] = '{rb: 4'd14, wb: 4'd2, lvl: 4'd4};
        occ[1] = '{rb: 4'd0,  wb: 4'd8, lvl: 4'd8};
        occ[2] = '{rb: 4'd3,  wb: 4'd3, lvl: 4'd0};
        ptr_override = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rptr     = bin2gray(occ[i].rb);
            bus.rq2_wptr = bin2gray(occ[i].wb);
            step();
            check($sformatf("rlevel_%0d", i), 32'(rlevel), 32'(occ[i].lvl));
        end
        ptr_override = 1'b0;
        refresh();
        step();

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            step();
            bus.m_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 63) == 0);
            if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0) write(8'($urandom));
        end
        flush = 1'b0;
        bus.m_ready = 1'b1;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        check("rand_fifo_empty", fifo_q.size(), 32'd0);
        check("rand_sb_empty", exp_q.size(), 32'd0);
        step();
        check("rand_m_valid", 32'(bus.m_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
